// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target receiver: bus widths, R/W encoding,
// receiver state encoding and the address-match helper.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_BYTE_W = 8;

    // R/W bit as it appears in the LSB of the address byte.
    localparam logic I2C_WRITE = 1'b0;
    localparam logic I2C_READ  = 1'b1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        DATA     = 3'd3,
        DATA_ACK = 3'd4,
        IGNORE   = 3'd5
    } i2c_state_e;

    // An address byte selects this target only for a write to own_addr.
    function automatic logic addr_match(input logic [I2C_BYTE_W-1:0] addr_byte,
                                        input logic [I2C_ADDR_W-1:0] own_addr);
        return (addr_byte[I2C_BYTE_W-1:1] == own_addr) && (addr_byte[0] == I2C_WRITE);
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// One bus line into the clk domain: 2-flop synchronizer, optional stability
// filter and rise/fall detection on the resulting level.
// Macro I2C_TARGET_GLITCH_FILTER_EN enables the FILTER_LEN-cycle filter;
// without it the synchronizer output feeds edge detection directly.
module i2c_line_sync #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    if (FILTER_LEN < 1) begin : g_bad_filter_len
        $error("i2c_line_sync: FILTER_LEN must be at least 1");
    end

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic level;

    // Two-flop synchronizer; idle bus level is high, so reset loads ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= line_i;
            sync_q <= meta_q;
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    localparam int CNT_W = $clog2(FILTER_LEN) + 1;

    logic             filt_q;
    logic             filt_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count consecutive samples that disagree with the filtered level; only a
    // run of FILTER_LEN of them moves the output, shorter pulses are dropped.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync_q != filt_q) begin
            if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                filt_d = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Filter state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign level = filt_q;
`else
    assign level = sync_q;
`endif

    // Previous level for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= level;
        end
    end

    assign level_o = level;
    assign rise_o  = level & ~prev_q;
    assign fall_o  = ~level & prev_q;

endmodule

// File: rtl/i2c_target_rx.sv
// Write-only I2C target receiver: detects START/STOP, matches a 7-bit
// address, ACKs writes and strobes each received data byte to the fabric.
// Macro I2C_TARGET_GLITCH_FILTER_EN adds a FILTER_LEN-cycle glitch filter on
// both bus lines (inside i2c_line_sync).
module i2c_target_rx
    import i2c_pkg::*;
#(
    parameter int FILTER_LEN = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [I2C_ADDR_W-1:0] own_address,
    input  logic                  scl,
    input  logic                  sda_in,
    output logic                  sda_oe,
    output logic [I2C_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  rx_first,
    output logic                  stop_seen,
    output logic                  busy,
    output logic [2:0]            dbg_state
);

    logic s_scl, scl_rise, scl_fall;
    logic s_sda, sda_rise, sda_fall;
    logic start_det, stop_det;

    i2c_line_sync #(.FILTER_LEN(FILTER_LEN)) u_scl_sync (
        .clk    (clk),
        .reset  (reset),
        .line_i (scl),
        .level_o(s_scl),
        .rise_o (scl_rise),
        .fall_o (scl_fall)
    );

    i2c_line_sync #(.FILTER_LEN(FILTER_LEN)) u_sda_sync (
        .clk    (clk),
        .reset  (reset),
        .line_i (sda_in),
        .level_o(s_sda),
        .rise_o (sda_rise),
        .fall_o (sda_fall)
    );

    // An SDA edge only counts as START/STOP while SCL is high and did not
    // itself just change; a simultaneous change is treated as an SCL edge.
    assign start_det = sda_fall & s_scl & ~scl_rise;
    assign stop_det  = sda_rise & s_scl & ~scl_rise;

    i2c_state_e            state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [I2C_BYTE_W-1:0] shift_q, shift_d;
    logic                  byte_full_q, byte_full_d;
    logic                  sda_oe_q, sda_oe_d;
    logic [I2C_BYTE_W-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  rx_first_q, rx_first_d;
    logic                  armed_q, armed_d;
    logic                  stop_seen_q, stop_seen_d;
    logic                  busy_q, busy_d;

    // Next-state and output logic. byte_full marks that 8 bits have been
    // sampled and the next SCL fall starts the ACK slot.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        byte_full_d = byte_full_q;
        sda_oe_d    = sda_oe_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        rx_first_d  = 1'b0;
        armed_d     = armed_q;
        stop_seen_d = 1'b0;
        busy_d      = busy_q;

        if (stop_det) begin
            state_d     = IDLE;
            bit_cnt_d   = '0;
            byte_full_d = 1'b0;
            sda_oe_d    = 1'b0;
            armed_d     = 1'b0;
            stop_seen_d = 1'b1;
            busy_d      = 1'b0;
        end else if (start_det) begin
            state_d     = ADDR;
            bit_cnt_d   = '0;
            byte_full_d = 1'b0;
            sda_oe_d    = 1'b0;
            armed_d     = 1'b0;
            busy_d      = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                end
                ADDR: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[I2C_BYTE_W-2:0], s_sda};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            byte_full_d = 1'b1;
                        end
                    end else if (scl_fall && byte_full_q) begin
                        byte_full_d = 1'b0;
                        if (addr_match(shift_q, own_address)) begin
                            state_d  = ADDR_ACK;
                            sda_oe_d = 1'b1;
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        state_d  = DATA;
                        sda_oe_d = 1'b0;
                        armed_d  = 1'b1;
                    end
                end
                DATA: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[I2C_BYTE_W-2:0], s_sda};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            byte_full_d = 1'b1;
                            rx_data_d   = {shift_q[I2C_BYTE_W-2:0], s_sda};
                            rx_valid_d  = 1'b1;
                            rx_first_d  = armed_q;
                            armed_d     = 1'b0;
                        end
                    end else if (scl_fall && byte_full_q) begin
                        byte_full_d = 1'b0;
                        state_d     = DATA_ACK;
                        sda_oe_d    = 1'b1;
                    end
                end
                DATA_ACK: begin
                    if (scl_fall) begin
                        state_d  = DATA;
                        sda_oe_d = 1'b0;
                    end
                end
                IGNORE: begin
                end
                default: begin
                    state_d  = IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            byte_full_q <= 1'b0;
            sda_oe_q    <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_first_q  <= 1'b0;
            armed_q     <= 1'b0;
            stop_seen_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            byte_full_q <= byte_full_d;
            sda_oe_q    <= sda_oe_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_first_q  <= rx_first_d;
            armed_q     <= armed_d;
            stop_seen_q <= stop_seen_d;
            busy_q      <= busy_d;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_first  = rx_first_q;
    assign stop_seen = stop_seen_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: an open-drain bus model driving SCL/SDA, a
// monitor collecting received bytes, table-driven and random transactions.
module tb_i2c_target_rx;
    import i2c_pkg::*;

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    localparam int FLEN = 3;
`else
    localparam int FLEN = 0;
`endif
    // SCL half period in clk cycles, and SCL-pin-fall to sda_oe-change latency.
    localparam int HP     = 12;
    localparam int OE_LAT = 3 + FLEN;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] own_address;
    logic       scl;
    logic       sda_drv;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_first;
    logic       stop_seen;
    logic       busy;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    // Open-drain wire: either side can pull SDA low.
    assign sda_in = sda_drv & ~sda_oe;

    i2c_target_rx #(.FILTER_LEN(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .own_address(own_address),
        .scl        (scl),
        .sda_in     (sda_in),
        .sda_oe     (sda_oe),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_first   (rx_first),
        .stop_seen  (stop_seen),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: collect {rx_first, rx_data} per strobe, count STOP pulses.
    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];
    int         stop_cnt   = 0;
    logic       busy_seen  = 1'b0;
    logic       valid_prev = 1'b0;

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (rx_valid) begin
                got_q.push_back({rx_first, rx_data});
                check("rx_valid_width", 32'(valid_prev), 32'd0);
            end
            if (stop_seen) stop_cnt++;
            if (busy) busy_seen = 1'b1;
        end
        valid_prev = rx_valid;
    end

    // Bus driver state.
    logic exp_prev_oe = 1'b0;
    logic exp_busy    = 1'b0;
    logic [7:0] tx_b[0:3];
    int         tx_n;

    // SCL-low phase: SCL has just been driven low. Check sda_oe holds its old
    // value one cycle before the expected latency and updates exactly on it.
    task automatic low_phase(input logic drv, input logic next_oe);
        for (int k = 1; k <= HP; k++) begin
            @(negedge clk);
            if (k == 2) sda_drv = drv;
            if (k == OE_LAT - 1) check("oe_hold", 32'(sda_oe), 32'(exp_prev_oe));
            if (k == OE_LAT) check("oe_update", 32'(sda_oe), 32'(next_oe));
        end
        exp_prev_oe = next_oe;
    endtask

    task automatic send_bit(input logic b, input logic exp_oe);
        low_phase(b, exp_oe);
        scl = 1'b1;
        for (int j = 1; j <= HP; j++) begin
            @(negedge clk);
            if (j == HP / 2) begin
                check("oe_scl_high", 32'(sda_oe), 32'(exp_oe));
                check("busy_in_bit", 32'(busy), 32'(exp_busy));
            end
        end
        scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i], 1'b0);
        send_bit(1'b1, ack);
    endtask

    task automatic send_start();
        if (scl == 1'b0) begin
            low_phase(1'b1, 1'b0);
            scl = 1'b1;
        end else begin
            sda_drv = 1'b1;
        end
        repeat (HP) @(negedge clk);
        sda_drv = 1'b0;
        repeat (HP) @(negedge clk);
        check("busy_after_start", 32'(busy), 32'd1);
        exp_busy = 1'b1;
        scl = 1'b0;
    endtask

    task automatic send_stop();
        low_phase(1'b0, 1'b0);
        scl = 1'b1;
        repeat (HP) @(negedge clk);
        sda_drv = 1'b1;
        repeat (HP) @(negedge clk);
        exp_busy = 1'b0;
        check("busy_after_stop", 32'(busy), 32'd0);
    endtask

    // Reference rule: the address byte is (address * 2 + rw); a write to our
    // own address is accepted, anything else is ignored.
    function automatic logic model_ack(input logic [7:0] ab, input logic [6:0] own);
        return ((int'(ab) / 2) == int'(own)) && ((int'(ab) % 2) == 0);
    endfunction

    // One transaction from tx_b[0..tx_n-1]; the first byte is the address.
    task automatic run_txn(input logic [6:0] own, input logic exp_ack,
                           input int exp_nv, input logic do_stop);
        int   stop0;
        logic m;
        own_address = own;
        got_q.delete();
        exp_q.delete();
        stop0 = stop_cnt;
        m = model_ack(tx_b[0], own);
        for (int i = 1; i < tx_n; i++) begin
            if (m) exp_q.push_back({(i == 1), tx_b[i]});
        end
        send_start();
        send_byte(tx_b[0], exp_ack);
        for (int i = 1; i < tx_n; i++) send_byte(tx_b[i], exp_ack);
        if (do_stop) begin
            send_stop();
            check("stop_seen_count", 32'(stop_cnt - stop0), 32'd1);
        end
        repeat (2) @(negedge clk);
        check("rx_count", 32'(got_q.size()), 32'(exp_nv));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check("rx_first_data", 32'(got_q[i]), 32'(exp_q[i]));
        end
    endtask

    typedef struct {
        logic [6:0] own;
        logic [7:0] b0, b1, b2, b3;
        int         n;
        logic       exp_ack;
        int         exp_nvalid;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] rb;
        int         stop0;
        int         nd;
        logic       m;

        vecs[0] = '{7'h1A, 8'h34, 8'h5A, 8'h00, 8'h00, 2, 1'b1, 1};
        vecs[1] = '{7'h1A, 8'h34, 8'h01, 8'h02, 8'h03, 4, 1'b1, 3};
        vecs[2] = '{7'h1A, 8'h36, 8'h11, 8'h22, 8'h00, 3, 1'b0, 0};
        vecs[3] = '{7'h1A, 8'h35, 8'h77, 8'h00, 8'h00, 2, 1'b0, 0};
        vecs[4] = '{7'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 2, 1'b1, 1};
        vecs[5] = '{7'h7F, 8'hFE, 8'h80, 8'h01, 8'h00, 3, 1'b1, 2};

        // Clock/reset.
        reset = 1'b1;
        scl = 1'b1;
        sda_drv = 1'b1;
        own_address = 7'h1A;
        repeat (3) @(negedge clk);
        check("reset_sda_oe", 32'(sda_oe), 32'd0);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_rx_first", 32'(rx_first), 32'd0);
        check("reset_stop_seen", 32'(stop_seen), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_state", 32'(dbg_state), 32'(IDLE));
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Table-driven directed transactions.
        for (int v = 0; v < 6; v++) begin
            tx_b[0] = vecs[v].b0;
            tx_b[1] = vecs[v].b1;
            tx_b[2] = vecs[v].b2;
            tx_b[3] = vecs[v].b3;
            tx_n    = vecs[v].n;
            run_txn(vecs[v].own, vecs[v].exp_ack, vecs[v].exp_nvalid, 1'b1);
            repeat (HP) @(negedge clk);
        end

        // Read address -> IGNORE, then repeated START with a matching write.
        tx_b[0] = 8'h35;
        tx_n = 1;
        run_txn(7'h1A, 1'b0, 0, 1'b0);
        check("state_ignore", 32'(dbg_state), 32'(IGNORE));
        check("busy_in_ignore", 32'(busy), 32'd1);
        tx_b[0] = 8'h34;
        tx_b[1] = 8'hC3;
        tx_n = 2;
        run_txn(7'h1A, 1'b1, 1, 1'b1);
        repeat (HP) @(negedge clk);

        // Reset while SDA is held low in DATA_ACK.
        own_address = 7'h1A;
        got_q.delete();
        send_start();
        send_byte(8'h34, 1'b1);
        rb = 8'h99;
        for (int i = 7; i >= 0; i--) send_bit(rb[i], 1'b0);
        repeat (2) @(negedge clk);
        sda_drv = 1'b1;
        repeat (OE_LAT) @(negedge clk);
        check("oe_before_reset", 32'(sda_oe), 32'd1);
        check("rx_before_reset", 32'(got_q.size()), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("oe_after_reset", 32'(sda_oe), 32'd0);
        check("busy_after_reset", 32'(busy), 32'd0);
        check("state_after_reset", 32'(dbg_state), 32'(IDLE));
        reset = 1'b0;
        got_q.delete();
        exp_busy = 1'b0;
        exp_prev_oe = 1'b0;
        rb = 8'hA5;
        for (int i = 7; i >= 0; i--) send_bit(rb[i], 1'b0);
        send_bit(1'b1, 1'b0);
        repeat (HP) @(negedge clk);
        scl = 1'b1;
        repeat (HP) @(negedge clk);
        check("no_rx_without_start", 32'(got_q.size()), 32'd0);
        tx_b[0] = 8'h34;
        tx_b[1] = 8'h3C;
        tx_n = 2;
        run_txn(7'h1A, 1'b1, 1, 1'b1);
        repeat (HP) @(negedge clk);

        // One-clk low glitch on SDA while SCL is high.
        busy_seen = 1'b0;
        stop0 = stop_cnt;
        @(negedge clk);
        sda_drv = 1'b0;
        @(negedge clk);
        sda_drv = 1'b1;
        repeat (HP) @(negedge clk);
        check("glitch_busy", 32'(busy_seen), (FLEN == 0) ? 32'd1 : 32'd0);
        check("glitch_stop", 32'(stop_cnt - stop0), (FLEN == 0) ? 32'd1 : 32'd0);
        check("glitch_idle", 32'(busy), 32'd0);

        // Randomized transactions against the reference rule.
        for (int t = 0; t < 16; t++) begin
            logic [6:0] own;
            own = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 1) == 1) tx_b[0] = {own, 1'b0};
            else tx_b[0] = 8'($urandom_range(0, 255));
            nd = $urandom_range(1, 3);
            for (int i = 1; i <= nd; i++) tx_b[i] = 8'($urandom_range(0, 255));
            tx_n = nd + 1;
            m = model_ack(tx_b[0], own);
            run_txn(own, m, m ? nd : 0, 1'b1);
            repeat ($urandom_range(2, HP)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
